// File: rtl/fifomult_param_pkg.sv
// fifomult_param shared types
// FSM states, parity tags, parity helper
package fifomult_param_pkg;

   typedef enum logic {S_A, S_B} state_t;

   typedef enum logic {PARITY_OK, PARITY_ERR} paritycheck_t;

   localparam int PAR_W = 64;

   function automatic logic even_parity(input logic [PAR_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/fifomult_param_fifo.sv
// fifomult_param result buffer
// first-word-fall-through FIFO with occupancy count
module fifomult_param_fifo
   import fifomult_param_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_C = DEPTH[CNT_W-1:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign valid  = (count != '0);
   assign do_pop = pop && valid;
   assign rdata  = valid ? mem[rd_ptr] : '0;

   // storage write; overflow is prevented upstream by busy_out
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wdata;
      if (!rst && push)
         assert (count != FULL_C);
   end

   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fifomult_param.sv
// fifomult_param top
// serial operand pairing, multiply/MAC, buffered output
module fifomult_param
   import fifomult_param_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                data_in_parity,
   input  logic                data_in_valid,
   input  logic                mode_mac,
   input  logic                acc_clear,
   output logic                busy_out,
   output logic [2*DATA_W-1:0] data_out,
   output logic                data_out_parity,
   output logic                data_out_valid,
   input  logic                data_out_ready,
   output logic                data_in_parity_error,
   output logic [CNT_W-1:0]    fifo_count
);

   localparam int PW = 2 * DATA_W;
   localparam logic [CNT_W:0] BUSY_TH = (CNT_W + 1)'(FIFO_DEPTH - 1);

   state_t             state;
   logic [DATA_W-1:0]  a_q;
   logic               err_a;
   logic               stage_full;
   logic               stage_err;
   logic [PW-1:0]      stage_data;
   logic [PW-1:0]      acc;
   logic [PW:0]        head;

   logic               accept;
   logic               accept_b;
   logic               err_in;
   logic               pair_err;
   logic               acc_upd;
   logic               pop_ok;
   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod;
   logic [PW-1:0]      mac_sum;
   logic [PW-1:0]      entry;
   logic [CNT_W:0]     occ_next;

   assign accept   = data_in_valid && !busy_out;
   assign accept_b = accept && (state == S_B);
   assign err_in   = data_in_parity !=
                     even_parity({{(PAR_W-DATA_W){1'b0}}, data_in});
   assign pair_err = err_a || err_in;
   assign acc_upd  = accept_b && mode_mac && !pair_err;
   assign pop_ok   = data_out_valid && data_out_ready;

   assign a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
   assign b_ext = {{DATA_W{data_in[DATA_W-1]}}, data_in};
   assign prod  = a_ext * b_ext;

   // entry value: zero on parity error, running sum in MAC mode
   always_comb begin
      mac_sum = (acc_clear ? '0 : acc) + prod;
      entry   = '0;
      if (!pair_err)
         entry = mode_mac ? mac_sum : prod;
   end

   // occupancy one edge ahead, so busy_out is exact when registered
   always_comb begin
      occ_next = {1'b0, fifo_count}
               + {{CNT_W{1'b0}}, stage_full}
               - {{CNT_W{1'b0}}, pop_ok}
               + {{CNT_W{1'b0}}, accept_b};
   end

   // operand FSM, product stage and back-pressure flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_A;
         a_q        <= '0;
         err_a      <= 1'b0;
         stage_full <= 1'b0;
         stage_err  <= 1'b0;
         stage_data <= '0;
         busy_out   <= 1'b0;
      end else begin
         stage_full <= accept_b;
         busy_out   <= (occ_next >= BUSY_TH);
         if (accept) begin
            unique case (state)
               S_A: begin
                  a_q   <= data_in;
                  err_a <= err_in;
                  state <= S_B;
               end
               S_B: begin
                  stage_data <= entry;
                  stage_err  <= pair_err;
                  state      <= S_A;
               end
               default: state <= S_A;
            endcase
         end
      end
   end

   // accumulator: MAC update absorbs a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else begin
         unique case (1'b1)
            acc_upd:                acc <= mac_sum;
            acc_clear && !acc_upd:  acc <= '0;
            default:                acc <= acc;
         endcase
      end
   end

   fifomult_param_fifo #(
      .WIDTH (PW + 1),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (stage_full),
      .wdata ({stage_err, stage_data}),
      .pop   (data_out_ready),
      .rdata (head),
      .valid (data_out_valid),
      .count (fifo_count)
   );

   assign data_out             = head[PW-1:0];
   assign data_in_parity_error = head[PW];
   assign data_out_parity      = ^head[PW-1:0];

endmodule

// File: tb/tb_fifomult_param.sv
// fifomult_param bench
// vector table plus scoreboard for stream, stall and reset cases
module tb_fifomult_param;
   import fifomult_param_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data_in = '0;
   logic        data_in_parity = 1'b0;
   logic        data_in_valid = 1'b0;
   logic        mode_mac = 1'b0;
   logic        acc_clear = 1'b0;
   logic        busy_out;
   logic [31:0] data_out;
   logic        data_out_parity;
   logic        data_out_valid;
   logic        data_out_ready = 1'b0;
   logic        data_in_parity_error;
   logic [3:0]  fifo_count;

   fifomult_param #(.DATA_W(16), .FIFO_DEPTH(8)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .data_in              (data_in),
      .data_in_parity       (data_in_parity),
      .data_in_valid        (data_in_valid),
      .mode_mac             (mode_mac),
      .acc_clear            (acc_clear),
      .busy_out             (busy_out),
      .data_out             (data_out),
      .data_out_parity      (data_out_parity),
      .data_out_valid       (data_out_valid),
      .data_out_ready       (data_out_ready),
      .data_in_parity_error (data_in_parity_error),
      .fifo_count           (fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      logic [15:0]  a;
      paritycheck_t pa;
      logic [15:0]  b;
      paritycheck_t pb;
      logic         mac;
      logic         clr;
      logic [31:0]  exp_d;
      logic         exp_e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   total = 0;
   int   passed = 0;

   function automatic void chk(string name, logic [63:0] got,
                               logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endfunction

   task automatic step(input logic v, input logic [15:0] d,
                       input paritycheck_t pc, input logic mac,
                       input logic clr, input logic rdy,
                       output logic accepted);
      exp_t e;
      logic p;
      @(negedge clk);
      p = even_parity({48'h0, d});
      data_in_valid  = v;
      data_in        = d;
      data_in_parity = (pc == PARITY_OK) ? p : ~p;
      mode_mac       = mac;
      acc_clear      = clr;
      data_out_ready = rdy;
      #1;
      accepted = v && !busy_out && !rst;
      if (data_out_valid && data_out_ready && !rst) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL pop_unexpected: got %0h expected none",
                     data_out);
         end else begin
            e = sb.pop_front();
            chk("data_out", 64'(data_out), 64'(e.data));
            chk("parity", 64'(data_out_parity), 64'(^e.data));
            chk("err_bit", 64'(data_in_parity_error), 64'(e.err));
         end
      end
   endtask

   task automatic idle(input logic rdy);
      logic a;
      step(1'b0, 16'h0, PARITY_OK, 1'b0, 1'b0, rdy, a);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        a;
      logic [15:0] a_word;
      logic        ph;
      logic [31:0] held;
      int          n;

      vecs[0]  = '{16'h0003, PARITY_OK,  16'hFFFC, PARITY_OK,
                   1'b0, 1'b0, 32'hFFFFFFF4, 1'b0};
      vecs[1]  = '{16'h8000, PARITY_OK,  16'h8000, PARITY_OK,
                   1'b0, 1'b0, 32'h40000000, 1'b0};
      vecs[2]  = '{16'h000A, PARITY_OK,  16'h0001, PARITY_OK,
                   1'b1, 1'b1, 32'd10, 1'b0};
      vecs[3]  = '{16'h0005, PARITY_ERR, 16'h0007, PARITY_OK,
                   1'b1, 1'b0, 32'd0, 1'b1};
      vecs[4]  = '{16'h0001, PARITY_OK,  16'h0001, PARITY_OK,
                   1'b1, 1'b0, 32'd11, 1'b0};
      vecs[5]  = '{16'h0002, PARITY_OK,  16'h0003, PARITY_OK,
                   1'b1, 1'b1, 32'd6, 1'b0};
      vecs[6]  = '{16'h0004, PARITY_OK,  16'h0005, PARITY_OK,
                   1'b1, 1'b0, 32'd26, 1'b0};
      vecs[7]  = '{16'hFFFF, PARITY_OK,  16'h0006, PARITY_OK,
                   1'b1, 1'b0, 32'd20, 1'b0};
      vecs[8]  = '{16'h0002, PARITY_OK,  16'h0002, PARITY_OK,
                   1'b1, 1'b1, 32'd4, 1'b0};
      vecs[9]  = '{16'h0006, PARITY_OK,  16'h0007, PARITY_ERR,
                   1'b0, 1'b0, 32'd0, 1'b1};
      vecs[10] = '{16'h0001, PARITY_OK,  16'h0001, PARITY_OK,
                   1'b1, 1'b0, 32'd5, 1'b0};
      vecs[11] = '{16'h7FFF, PARITY_OK,  16'h8000, PARITY_OK,
                   1'b0, 1'b0, 32'hC0008000, 1'b0};

      // reset state
      rst = 1'b1;
      idle(1'b0);
      idle(1'b0);
      chk("rst_busy", 64'(busy_out), 64'd0);
      chk("rst_valid", 64'(data_out_valid), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_data", 64'(data_out), 64'd0);
      chk("rst_parity", 64'(data_out_parity), 64'd0);
      chk("rst_err", 64'(data_in_parity_error), 64'd0);
      rst = 1'b0;
      idle(1'b1);

      // table vectors, one pair at a time with latency checks
      foreach (vecs[i]) begin
         step(1'b1, vecs[i].a, vecs[i].pa, 1'b0, 1'b0, 1'b1, a);
         chk("acc_a", 64'(a), 64'd1);
         step(1'b1, vecs[i].b, vecs[i].pb, vecs[i].mac, vecs[i].clr,
              1'b1, a);
         chk("acc_b", 64'(a), 64'd1);
         sb.push_back('{vecs[i].exp_d, vecs[i].exp_e});
         idle(1'b1);
         chk("lat_early", 64'(data_out_valid), 64'd0);
         idle(1'b1);
         chk("lat_valid", 64'(data_out_valid), 64'd1);
         idle(1'b1);
         chk("empty_after", 64'(fifo_count), 64'd0);
      end

      // stall the consumer and stream 20 pairs
      ph = 1'b0;
      a_word = '0;
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 16'(k + 1), PARITY_OK, 1'b0, 1'b0, 1'b0, a);
         if (a && !ph) begin
            a_word = 16'(k + 1);
            ph = 1'b1;
         end else if (a) begin
            sb.push_back('{32'(int'(a_word) * (k + 1)), 1'b0});
            ph = 1'b0;
         end
      end
      idle(1'b0);
      idle(1'b0);
      chk("stall_busy", 64'(busy_out), 64'd1);
      chk("stall_count", 64'(fifo_count), 64'd7);
      chk("stall_valid", 64'(data_out_valid), 64'd1);
      held = sb.size() > 0 ? sb[0].data : 32'hDEAD;
      chk("hold_head0", 64'(data_out), 64'(held));
      idle(1'b0);
      chk("hold_head1", 64'(data_out), 64'(held));

      // drain in order, bounded
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         idle(1'b1);
         n++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
      idle(1'b1);
      chk("drain_count", 64'(fifo_count), 64'd0);
      chk("drain_valid", 64'(data_out_valid), 64'd0);
      chk("drain_data", 64'(data_out), 64'd0);
      chk("drain_busy", 64'(busy_out), 64'd0);

      // reset between A and B discards the stale operand
      step(1'b1, 16'd100, PARITY_OK, 1'b0, 1'b0, 1'b1, a);
      rst = 1'b1;
      idle(1'b1);
      rst = 1'b0;
      step(1'b1, 16'd9, PARITY_OK, 1'b0, 1'b0, 1'b1, a);
      step(1'b1, 16'd9, PARITY_OK, 1'b0, 1'b0, 1'b1, a);
      sb.push_back('{32'd81, 1'b0});
      n = 0;
      while (sb.size() != 0 && n < 10) begin
         idle(1'b1);
         n++;
      end
      chk("rst_pair_left", 64'(sb.size()), 64'd0);
      idle(1'b1);
      chk("rst_pair_single", 64'(fifo_count), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
